// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry FIFO of {pc, inst} between fetch and decode,
// with a registered decode-side output stage, flush, and a sticky overflow flag.
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic [CNT_W-1:0]  count,
   output logic              ovf
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              ovf_reg;
   logic              id_valid_reg;
   logic [ADDR_W-1:0] id_pc_reg;
   logic [INST_W-1:0] id_inst_reg;

   logic push, pop, drop;
   logic unused_stall;

   assign unused_stall = ^{stall[5:3], stall[0]};

   // Readiness looks only at the registered count; a same-cycle pop does not free a slot.
   assign if_ready = (count_reg != CNT_W'(DEPTH));
   assign push     = if_valid & ~stall[1] & if_ready & ~flush;
   assign drop     = if_valid & ~stall[1] & ~if_ready & ~flush;
   assign pop      = ~stall[2] & ~flush & (count_reg != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= if_pc;
         inst_mem[wr_ptr_reg] <= if_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       ovf_reg <= 1'b0;
      else if (drop) ovf_reg <= 1'b1;
   end

   // Decode stage: load on pop, bubble when advancing on empty, hold under decode stall.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         id_valid_reg <= 1'b0;
         id_pc_reg    <= '0;
         id_inst_reg  <= '0;
      end else if (!stall[2]) begin
         if (pop) begin
            id_valid_reg <= 1'b1;
            id_pc_reg    <= pc_mem[rd_ptr_reg];
            id_inst_reg  <= inst_mem[rd_ptr_reg];
         end else begin
            id_valid_reg <= 1'b0;
            id_pc_reg    <= '0;
            id_inst_reg  <= '0;
         end
      end
   end

   assign id_valid = id_valid_reg;
   assign id_pc    = id_pc_reg;
   assign id_inst  = id_inst_reg;
   assign count    = count_reg;
   assign ovf      = ovf_reg;
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a queue-based model checked every cycle, directed scenarios
// with hand-computed literals, then randomized traffic.
module tb_if_id_queue;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [5:0]       stall = '0;
   logic             flush = 1'b0;
   logic             if_valid = 1'b0;
   logic [31:0]      if_pc = '0;
   logic [31:0]      if_inst = '0;
   logic             if_ready;
   logic             id_valid;
   logic [31:0]      id_pc;
   logic [31:0]      id_inst;
   logic [CNT_W-1:0] count;
   logic             ovf;

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
      .id_inst(id_inst), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: queue contents plus what decode currently sees.
   logic [63:0] mq[$];
   bit          m_valid = 0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_inst = '0;
   bit          m_ovf = 0;
   bit          chk_en = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          max_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
   endtask

   // Apply current inputs for one clock edge and advance the model from the rules.
   task automatic tick();
      logic [63:0] nq[$];
      logic [63:0] e;
      bit          nv, no, full;
      logic [31:0] np, ni;
      nq = mq; nv = m_valid; np = m_pc; ni = m_inst; no = m_ovf;
      full = (mq.size() == DEPTH);
      if (rst) begin
         nq.delete(); nv = 0; np = 0; ni = 0; no = 0;
      end else if (flush) begin
         nq.delete(); nv = 0; np = 0; ni = 0;
      end else begin
         if (!stall[2]) begin
            if (nq.size() > 0) begin
               e = nq.pop_front();
               nv = 1; np = e[63:32]; ni = e[31:0];
            end else begin
               nv = 0; np = 0; ni = 0;
            end
         end
         if (if_valid && !stall[1]) begin
            if (full) no = 1;
            else nq.push_back({if_pc, if_inst});
         end
      end
      @(posedge clk);
      #1;
      mq = nq; m_valid = nv; m_pc = np; m_inst = ni; m_ovf = no;
      if (mq.size() > max_count) max_count = mq.size();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("id_valid", 64'(id_valid), 64'(m_valid));
         chk("id_pc", 64'(id_pc), 64'(m_pc));
         chk("id_inst", 64'(id_inst), 64'(m_inst));
         chk("count", 64'(count), 64'(mq.size()));
         chk("if_ready", 64'(if_ready), 64'(mq.size() != DEPTH));
         chk("ovf", 64'(ovf), 64'(m_ovf));
      end
   end

   task automatic push_pc(input logic [31:0] pc);
      if_valid = 1; if_pc = pc; if_inst = pc ^ 32'hA5A5_0000;
   endtask

   initial begin
      tick(); tick();
      rst = 0;
      chk_en = 1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_id_valid", 64'(id_valid), 64'd0);

      // Basic flow
      max_count = 0;
      for (int i = 0; i < 3; i++) begin
         push_pc(32'h100 + 32'(4 * i));
         tick();
         if (i == 0) chk("basic_latency_bubble", 64'(id_valid), 64'd0);
         if (i == 1) chk("basic_pc0", 64'(id_pc), 64'h100);
         if (i == 2) chk("basic_pc1", 64'(id_pc), 64'h104);
      end
      if_valid = 0;
      tick(); chk("basic_pc2", 64'(id_pc), 64'h108);
      chk("basic_inst2", 64'(id_inst), 64'h108 ^ 64'hA5A5_0000);
      tick(); chk("basic_bubble_pc", 64'(id_pc), 64'd0);
      chk("basic_count_peak", 64'(max_count), 64'd1);
      $display("basic flow done at %0t", $time);

      // Decode stall fill and overflow
      stall = 6'b000100;
      for (int i = 0; i < 6; i++) begin
         push_pc(32'h200 + 32'(4 * i));
         tick();
         if (i == 3) begin
            chk("fill_count4", 64'(count), 64'd4);
            chk("fill_not_ready", 64'(if_ready), 64'd0);
            chk("fill_no_ovf_yet", 64'(ovf), 64'd0);
         end
      end
      chk("fill_ovf", 64'(ovf), 64'd1);
      if_valid = 0; stall = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_pc", 64'(id_pc), 64'h200 + 64'(4 * i));
      end
      tick(); chk("drain_bubble", 64'(id_valid), 64'd0);
      $display("stall fill done at %0t", $time);

      // Flush while full
      stall = 6'b000100;
      for (int i = 0; i < 4; i++) begin push_pc(32'h300 + 32'(4 * i)); tick(); end
      push_pc(32'h3F0); flush = 1; tick();
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_id_valid", 64'(id_valid), 64'd0);
      chk("flush_id_pc", 64'(id_pc), 64'd0);
      flush = 0; stall = 6'b000000; push_pc(32'h400); tick();
      if_valid = 0; tick();
      chk("post_flush_pc", 64'(id_pc), 64'h400);
      tick();
      $display("flush done at %0t", $time);

      // Fetch stall: no pushes, queue drains
      stall = 6'b000100;
      push_pc(32'h500); tick(); push_pc(32'h504); tick();
      stall = 6'b000010; push_pc(32'h5F0);
      tick(); chk("ifstall_pc0", 64'(id_pc), 64'h500);
      tick(); chk("ifstall_pc1", 64'(id_pc), 64'h504);
      tick(); chk("ifstall_bubble", 64'(id_valid), 64'd0);
      chk("ifstall_count", 64'(count), 64'd0);
      $display("fetch stall done at %0t", $time);

      // Reset mid-stream with ovf set
      stall = 6'b000000; push_pc(32'h580); tick(); tick();
      rst = 1; tick(); rst = 0;
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      push_pc(32'h600); tick(); if_valid = 0; tick();
      chk("post_rst_pc", 64'(id_pc), 64'h600);
      $display("reset done at %0t", $time);

      // Randomized traffic (covers pointer wrap, simultaneous push/pop)
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         flush    = ($urandom_range(0, 59) == 0);
         stall    = 6'($urandom);
         stall[1] = ($urandom_range(0, 9) < 3);
         stall[2] = ($urandom_range(0, 9) < 4);
         if_valid = ($urandom_range(0, 9) < 7);
         if_pc    = $urandom;
         if_inst  = $urandom;
         tick();
      end
      rst = 0; flush = 0; if_valid = 0; stall = 0;
      tick(); tick(); tick(); tick(); tick();
      chk("final_count", 64'(count), 64'd0);
      chk("count_bound", 64'(max_count <= DEPTH), 64'd1);
      @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
